// File: rtl/ifu_fetch.sv
// Instruction fetch stage. Owns the PC and keeps at most one instruction-memory
// request in flight. The returned word is held for decode with its fields
// pre-sliced. Redirects from the jump/branch path retarget the PC; a response
// that belongs to a superseded request is discarded via the kill flag.
module ifu_fetch #(
    parameter int unsigned        ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h0000_0000_8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_resp_valid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              if_valid_o,
    input  logic              if_ready_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_inst_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        func3_o,
    output logic [6:0]        func7_o,
    output logic              fault_o
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              kill_q, kill_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;

    logic redir_ok;
    logic redir_bad;
    logic accept;

    assign redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign accept    = (state_q == StReq) && imem_req_ready_i;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            inst_q  <= 32'h0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end

    // Next state; a redirect outranks both response capture and decode consumption
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    if (redir_bad) state_d = StFault;
                end
            end
            StReq: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    // An accepted request is now stale; flag its response for drop
                    kill_d = accept;
                    if (redir_bad) state_d = StFault;
                    else if (accept) state_d = StWait;
                end else if (accept) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    if (imem_resp_valid_i) begin
                        kill_d  = 1'b0;
                        state_d = redir_bad ? StFault : StReq;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = redir_bad ? StFault : StWait;
                    end
                end else if (imem_resp_valid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        inst_d  = imem_rdata_i;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = redir_bad ? StFault : StReq;
                end else if (if_ready_i) begin
                    state_d = StReq;
                end
            end
            StFault: begin
                if (imem_resp_valid_i) kill_d = 1'b0;
                if (redirect_i) pc_d = redirect_pc_i;
                if (redir_ok) begin
                    // Still owed a stale response: wait it out before a new request
                    if (kill_q && !imem_resp_valid_i) begin
                        state_d = StWait;
                    end else begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and the instruction buffer
    always_comb begin
        imem_req_valid_o = (state_q == StReq);
        imem_addr_o      = pc_q;
        if_valid_o       = (state_q == StHold);
        fault_o          = (state_q == StFault);
        if_pc_o          = ipc_q;
        if_inst_o        = inst_q;
        opcode_o         = inst_q[6:0];
        func3_o          = inst_q[14:12];
        func7_o          = inst_q[31:25];
    end

endmodule
